// File: rtl/dout_sig_pkg.sv
// Shared constants, FSM state type and the per-lane rotate-XOR fold used by
// the D_out signature serializer.
package dout_sig_pkg;

    localparam int LANES  = 8;
    localparam int DW     = 32;
    localparam logic [3:0] HDR = 4'hA;

    localparam int NIB_TOTAL = LANES * DW / 4;
    localparam int NCNT_W    = $clog2(NIB_TOTAL);
    localparam int RIDX_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_RIDX,
        ST_PAY
    } state_t;

    function automatic logic [DW-1:0] sig_fold(input logic [DW-1:0] sig,
                                               input logic [DW-1:0] word);
        return {sig[DW-2:0], sig[DW-1]} ^ word;
    endfunction

endpackage

// File: rtl/dout_sig_serializer_lane_sig.sv
// One lane's live signature. sig_next already includes a word written this
// cycle, so the parent can capture it on the same edge that clears the lane.
module lane_sig
    import dout_sig_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          write,
    input  logic [DW-1:0] din,
    input  logic          clear,
    output logic [DW-1:0] sig_next
);

    logic [DW-1:0] sig_q;
    logic [DW-1:0] sig_d;

    always_comb begin
        sig_next = write ? sig_fold(sig_q, din) : sig_q;
        sig_d    = clear ? '0 : sig_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

endmodule

// File: rtl/dout_sig_serializer.sv
// Folds the kernel's output FIFO writes into per-lane signatures and, on each
// kernel_done, streams a framed nibble snapshot (HDR, run index, 64 nibbles).
module dout_sig_serializer
    import dout_sig_pkg::*;
(
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic [LANES*DW-1:0]   lane_din,
    input  logic [LANES-1:0]      lane_write,
    input  logic                  kernel_done,
    output logic [3:0]            data_out,
    output logic                  data_valid,
    output logic                  busy,
    output logic                  probe_out
);

    localparam logic [NCNT_W-1:0] LAST_NIB = NCNT_W'(NIB_TOTAL - 1);

    // Reset asserts asynchronously, releases two clocks after ap_rst_n rises.
    logic [1:0] rst_sync_q;
    logic [1:0] rst_sync_d;
    logic       rst_n_int;

    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_n_int  = rst_sync_q[1];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    logic [LANES*DW-1:0] cap_flat;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        lane_sig u_lane_sig (
            .clk      (ap_clk),
            .rst_n    (rst_n_int),
            .write    (lane_write[gi]),
            .din      (lane_din[gi*DW +: DW]),
            .clear    (kernel_done),
            .sig_next (cap_flat[gi*DW +: DW])
        );
    end

    state_t              state_q, state_d;
    logic [NCNT_W-1:0]   cnt_q, cnt_d;
    logic [LANES*DW-1:0] shadow_q, shadow_d;
    logic [LANES*DW-1:0] hold_q, hold_d;
    logic [RIDX_W-1:0]   shadow_ridx_q, shadow_ridx_d;
    logic [RIDX_W-1:0]   hold_ridx_q, hold_ridx_d;
    logic [RIDX_W-1:0]   run_idx_q, run_idx_d;
    logic                pending_q, pending_d;
    logic                ovf_q, ovf_d;
    logic [3:0]          data_out_q, data_out_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                consume;
    logic                start_direct;
    logic [7:0]          bit_idx;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shadow_d      = shadow_q;
        shadow_ridx_d = shadow_ridx_q;
        hold_d        = hold_q;
        hold_ridx_d   = hold_ridx_q;
        run_idx_d     = run_idx_q;
        pending_d     = pending_q;
        ovf_d         = ovf_q;

        consume      = (state_q == ST_IDLE) && pending_q;
        start_direct = (state_q == ST_IDLE) && !pending_q && kernel_done;

        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    shadow_d      = hold_q;
                    shadow_ridx_d = hold_ridx_q;
                    pending_d     = 1'b0;
                    state_d       = ST_HDR;
                end else if (kernel_done) begin
                    shadow_d      = cap_flat;
                    shadow_ridx_d = run_idx_q;
                    run_idx_d     = run_idx_q + 4'd1;
                    state_d       = ST_HDR;
                end
            end
            ST_HDR: begin
                state_d = ST_RIDX;
            end
            ST_RIDX: begin
                cnt_d   = '0;
                state_d = ST_PAY;
            end
            ST_PAY: begin
                if (cnt_q == LAST_NIB) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Runs finishing while a frame is out go to the one-deep hold bank;
        // a full hold bank that is not being drained this cycle drops the run.
        if (kernel_done && !start_direct) begin
            if (pending_q && !consume) begin
                ovf_d = 1'b1;
            end else begin
                hold_d      = cap_flat;
                hold_ridx_d = run_idx_q;
                pending_d   = 1'b1;
                run_idx_d   = run_idx_q + 4'd1;
            end
        end
    end

    // Outputs are registered from next-state so each nibble appears the cycle
    // after the state that selects it is decided.
    always_comb begin
        bit_idx    = {cnt_d[5:3], 5'b0} + {3'b0, ~cnt_d[2:0], 2'b0};
        valid_d    = (state_d != ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
        data_out_d = 4'h0;
        case (state_d)
            ST_HDR:  data_out_d = HDR;
            ST_RIDX: data_out_d = shadow_ridx_d;
            ST_PAY:  data_out_d = shadow_d[bit_idx +: 4];
            default: data_out_d = 4'h0;
        endcase
    end

    always_ff @(posedge ap_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            shadow_q      <= '0;
            hold_q        <= '0;
            shadow_ridx_q <= '0;
            hold_ridx_q   <= '0;
            run_idx_q     <= '0;
            pending_q     <= 1'b0;
            ovf_q         <= 1'b0;
            data_out_q    <= 4'h0;
            valid_q       <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shadow_q      <= shadow_d;
            hold_q        <= hold_d;
            shadow_ridx_q <= shadow_ridx_d;
            hold_ridx_q   <= hold_ridx_d;
            run_idx_q     <= run_idx_d;
            pending_q     <= pending_d;
            ovf_q         <= ovf_d;
            data_out_q    <= data_out_d;
            valid_q       <= valid_d;
            busy_q        <= busy_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = valid_q;
    assign busy       = busy_q;
    assign probe_out  = ovf_q;

endmodule
